// File: rtl/output_layer_sequencer_if.sv
// Vector-in / weight-fetch / scalar-out bundle for the output layer sequencer.
// The master side feeds vectors and weight data; the slave side is the sequencer.
interface output_layer_sequencer_if #(
  parameter int N_IN   = 16,
  parameter int DATA_W = 16
);
  localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic                         valid_in;
  logic                         ready_in;
  logic [N_IN-1:0][DATA_W-1:0]  input_data;
  logic [DATA_W-1:0]            bias;
  logic                         w_rd_en;
  logic [AW-1:0]                w_addr;
  logic [DATA_W-1:0]            w_data;
  logic [DATA_W-1:0]            final_output;
  logic                         valid_out;
  logic                         busy;

  modport master (
    output valid_in, input_data, bias, w_data,
    input  ready_in, w_rd_en, w_addr, final_output, valid_out, busy
  );

  modport slave (
    input  valid_in, input_data, bias, w_data,
    output ready_in, w_rd_en, w_addr, final_output, valid_out, busy
  );
endinterface

// File: rtl/output_layer_sequencer.sv
// Serial dense output layer on one signed MAC: accept vector+bias, fetch N_IN weights, round/saturate.
// Result pulses N_IN+2 edges after accept; a new vector may be accepted on the FINAL edge for gapless streaming.
module output_layer_sequencer #(
  parameter int N_IN      = 16,
  parameter int DATA_W    = 16,
  parameter int FRAC_BITS = 8,
  parameter int ACC_W     = 40
) (
  input  logic                      clk,
  input  logic                      reset,
  output_layer_sequencer_if.slave   bus
);
  localparam int AW    = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int CNT_W = $clog2(N_IN + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MAC   = 2'd1;
  localparam logic [1:0] S_FINAL = 2'd2;

  localparam logic signed [ACC_W:0] SAT_HI = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_LO = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

  logic [1:0]                   state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic signed [ACC_W-1:0]      acc_q, acc_d;
  logic [N_IN-1:0][DATA_W-1:0]  x_q, x_d;
  logic [DATA_W-1:0]            bias_q, bias_d;
  logic [DATA_W-1:0]            out_q, out_d;
  logic                         vld_q, vld_d;

  logic                         ready;
  logic                         accept;
  logic                         rd_en;
  logic [AW-1:0]                x_idx;
  logic signed [2*DATA_W-1:0]   prod;
  logic signed [ACC_W-1:0]      acc_nxt;
  logic signed [ACC_W:0]        sum_r;
  logic signed [ACC_W:0]        shr_r;
  logic [DATA_W-1:0]            sat_r;

  // FINAL also counts as ready so streamed vectors see only the two dead fetch cycles.
  assign ready  = (state_q == S_IDLE) || (state_q == S_FINAL);
  assign accept = bus.valid_in && ready;
  assign rd_en  = (state_q == S_MAC) && (cnt_q < CNT_W'(N_IN));

  assign bus.ready_in     = ready;
  assign bus.busy         = ~ready;
  assign bus.w_rd_en      = rd_en;
  assign bus.w_addr       = rd_en ? cnt_q[AW-1:0] : '0;
  assign bus.final_output = out_q;
  assign bus.valid_out    = vld_q;

  // Weight for index cnt-1 arrives now; the low bits wrap cleanly to N_IN-1 at cnt==N_IN.
  assign x_idx   = cnt_q[AW-1:0] - AW'(1);
  assign prod    = $signed(bus.w_data) * $signed(x_q[x_idx]);
  assign acc_nxt = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

  assign sum_r = {acc_q[ACC_W-1], acc_q}
               + ({{(ACC_W+1-DATA_W){bias_q[DATA_W-1]}}, bias_q} <<< FRAC_BITS)
               + ((ACC_W+1)'(1) << (FRAC_BITS - 1));
  assign shr_r = sum_r >>> FRAC_BITS;
  assign sat_r = (shr_r > SAT_HI) ? SAT_HI[DATA_W-1:0] :
                 (shr_r < SAT_LO) ? SAT_LO[DATA_W-1:0] : shr_r[DATA_W-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    x_d     = x_q;
    bias_d  = bias_q;
    out_d   = out_q;
    vld_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          x_d     = bus.input_data;
          bias_d  = bus.bias;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q != '0) acc_d = acc_nxt;
        if (cnt_q == CNT_W'(N_IN)) state_d = S_FINAL;
      end
      S_FINAL: begin
        out_d   = sat_r;
        vld_d   = 1'b1;
        state_d = S_IDLE;
        if (accept) begin
          x_d     = bus.input_data;
          bias_d  = bus.bias;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = S_MAC;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      x_q     <= '0;
      bias_q  <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      bias_q  <= bias_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
    end
  end
endmodule

// File: tb/tb_output_layer_sequencer.sv
// Scoreboard bench for output_layer_sequencer: expected results queued at accept, popped on valid_out.
module tb_output_layer_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  output_layer_sequencer_if #(.N_IN(16), .DATA_W(16)) bus_if ();

  output_layer_sequencer #(.N_IN(16), .DATA_W(16), .FRAC_BITS(8), .ACC_W(40)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  logic signed [15:0] w_mem [16];
  logic signed [15:0] x_v   [16];
  logic signed [15:0] bias_v;
  int exp_q[$];
  int n_pass  = 0;
  int n_total = 0;

  // Weight memory: one-cycle read latency, junk when not reading.
  always @(posedge clk) begin
    if (bus_if.w_rd_en) bus_if.w_data <= w_mem[bus_if.w_addr];
    else                bus_if.w_data <= 16'hDEAD;
  end

  function automatic int model();
    longint acc, s, r;
    acc = 0;
    for (int i = 0; i < 16; i++) acc += longint'(x_v[i]) * longint'(w_mem[i]);
    s = acc + (longint'(bias_v) * 256) + 128;
    r = s >>> 8;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  task automatic drive_vec();
    for (int i = 0; i < 16; i++) bus_if.input_data[i] = x_v[i];
    bus_if.bias = bias_v;
  endtask

  task automatic fill(input int xv, input int wv, input int bv, input bit only0);
    for (int i = 0; i < 16; i++) begin
      x_v[i]   = (only0 && i != 0) ? 16'sd0 : 16'(xv);
      w_mem[i] = (only0 && i != 0) ? 16'sd0 : 16'(wv);
    end
    bias_v = 16'(bv);
  endtask

  task automatic accept_vec(input int expv, output bit ok);
    int k;
    @(negedge clk);
    drive_vec();
    bus_if.valid_in = 1'b1;
    for (k = 0; k < 40; k++) begin
      if (bus_if.ready_in) break;
      @(negedge clk);
    end
    ok = (k < 40);
    @(posedge clk);
    if (ok) exp_q.push_back(expv);
    #1 bus_if.valid_in = 1'b0;
  endtask

  task automatic wait_vout(output int cyc);
    for (cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (bus_if.valid_out) break;
    end
    if (cyc == 40) cyc = -1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    n_total++; if (bus_if.final_output !== 16'd0) $display("FAIL rst_out got %0d want 0", bus_if.final_output); else n_pass++;
    n_total++; if (bus_if.valid_out !== 1'b0) $display("FAIL rst_vout got %0b want 0", bus_if.valid_out); else n_pass++;
    n_total++; if (bus_if.ready_in !== 1'b1) $display("FAIL rst_ready got %0b want 1", bus_if.ready_in); else n_pass++;
    n_total++; if (bus_if.w_rd_en !== 1'b0 || bus_if.w_addr !== 4'd0)
      $display("FAIL rst_wrd got en=%0b addr=%0d want 0/0", bus_if.w_rd_en, bus_if.w_addr); else n_pass++;
    n_total++; if (bus_if.busy !== 1'b0) $display("FAIL rst_busy got %0b want 0", bus_if.busy); else n_pass++;
  endtask

  task automatic test_basic();
    bit ok; int cyc, got, e;
    fill(256, 256, 0, 1'b0);
    accept_vec(4096, ok);
    n_total++; if (!ok) $display("FAIL basic_accept got timeout want accept"); else n_pass++;
    wait_vout(cyc);
    n_total++; if (cyc !== 18) $display("FAIL basic_latency got %0d want 18", cyc); else n_pass++;
    if (cyc > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = int'($signed(bus_if.final_output));
      n_total++; if (got !== e) $display("FAIL basic_value got %0d want %0d", got, e); else n_pass++;
      n_total++; if (bus_if.ready_in !== 1'b1) $display("FAIL basic_ready_at_vout got %0b want 1", bus_if.ready_in); else n_pass++;
      @(negedge clk);
      n_total++; if (bus_if.valid_out !== 1'b0) $display("FAIL basic_pulse_width got %0b want 0", bus_if.valid_out); else n_pass++;
      n_total++; if (int'($signed(bus_if.final_output)) !== e)
        $display("FAIL basic_hold got %0d want %0d", $signed(bus_if.final_output), e); else n_pass++;
    end
  endtask

  task automatic test_values();
    int tx[5] = '{256, 32767, 32767, 1, 1};
    int tw[5] = '{256, 32767, -32768, 128, 127};
    int tb[5] = '{-512, 0, 0, 0, 0};
    int te[5] = '{3584, 32767, -32768, 1, 0};
    bit t0[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bit ok; int cyc, got, e;
    for (int c = 0; c < 5; c++) begin
      fill(tx[c], tw[c], tb[c], t0[c]);
      accept_vec(te[c], ok);
      wait_vout(cyc);
      n_total++;
      if (!ok || cyc < 0 || exp_q.size() == 0) $display("FAIL value_%0d got no result want %0d", c, te[c]);
      else begin
        e = exp_q.pop_front();
        got = int'($signed(bus_if.final_output));
        if (got !== e) $display("FAIL value_%0d got %0d want %0d", c, got, e); else n_pass++;
      end
    end
  endtask

  task automatic test_random();
    bit ok; int cyc, got, e;
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < 16; i++) begin
        w_mem[i] = (v == 2) ? 16'($urandom) : 16'($urandom_range(0, 2047) - 1024);
        x_v[i]   = (v == 2) ? 16'($urandom) : 16'($urandom_range(0, 2047) - 1024);
      end
      bias_v = 16'($urandom_range(0, 4095) - 2048);
      accept_vec(model(), ok);
      wait_vout(cyc);
      n_total++;
      if (!ok || cyc != 18 || exp_q.size() == 0) $display("FAIL random_%0d got latency %0d want 18", v, cyc);
      else begin
        e = exp_q.pop_front();
        got = int'($signed(bus_if.final_output));
        if (got !== e) $display("FAIL random_%0d got %0d want %0d", v, got, e); else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int k, pulses, p0, p1, got, e, exp_addr;
    bit exp_rd;
    for (int i = 0; i < 16; i++) begin
      w_mem[i] = 16'(i * 37 - 200);
      x_v[i]   = 16'(i * 50 - 300);
    end
    bias_v = 16'sd100;
    @(negedge clk);
    drive_vec();
    bus_if.valid_in = 1'b1;
    for (k = 0; k < 40; k++) begin
      if (bus_if.ready_in) break;
      @(negedge clk);
    end
    @(posedge clk);
    exp_q.push_back(model());
    pulses = 0; p0 = -1; p1 = -1;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      exp_rd   = (c <= 15) || (c >= 18 && c <= 33);
      exp_addr = (c <= 15) ? c : c - 18;
      n_total++;
      if (bus_if.w_rd_en !== exp_rd || (exp_rd && bus_if.w_addr !== 4'(exp_addr)))
        $display("FAIL b2b_fetch_c%0d got en=%0b addr=%0d want en=%0b addr=%0d",
                 c, bus_if.w_rd_en, bus_if.w_addr, exp_rd, exp_addr);
      else n_pass++;
      if (bus_if.valid_out) begin
        if (pulses == 0) p0 = c; else p1 = c;
        pulses++;
        n_total++;
        if (exp_q.size() == 0) $display("FAIL b2b_value got unexpected pulse want none");
        else begin
          e = exp_q.pop_front();
          got = int'($signed(bus_if.final_output));
          if (got !== e) $display("FAIL b2b_value got %0d want %0d", got, e); else n_pass++;
        end
      end
      if (c >= 1 && c <= 8) begin
        for (int i = 0; i < 16; i++) bus_if.input_data[i] = 16'($urandom);
        bus_if.bias = 16'($urandom);
      end else if (c == 9) begin
        for (int i = 0; i < 16; i++) x_v[i] = 16'(700 - i * 90);
        bias_v = -16'sd300;
        drive_vec();
      end else if (c == 17) begin
        exp_q.push_back(model());
      end else if (c == 18) begin
        bus_if.valid_in = 1'b0;
        for (int i = 0; i < 16; i++) bus_if.input_data[i] = 16'($urandom);
        bus_if.bias = 16'($urandom);
      end
    end
    n_total++; if (k >= 40 || pulses !== 2) $display("FAIL b2b_pulses got %0d want 2", pulses); else n_pass++;
    n_total++; if (p0 !== 18 || p1 !== 36) $display("FAIL b2b_spacing got %0d,%0d want 18,36", p0, p1); else n_pass++;
  endtask

  task automatic test_abort();
    bit ok; int cyc, pulses, got, e;
    fill(256, 256, 0, 1'b0);
    accept_vec(4096, ok);
    repeat (9) @(negedge clk);
    n_total++; if (!ok || bus_if.w_addr !== 4'd8) $display("FAIL abort_pos got addr=%0d want 8", bus_if.w_addr); else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    void'(exp_q.pop_front());
    n_total++; if (bus_if.ready_in !== 1'b1 || bus_if.w_rd_en !== 1'b0)
      $display("FAIL abort_ready got ready=%0b en=%0b want 1/0", bus_if.ready_in, bus_if.w_rd_en); else n_pass++;
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      if (bus_if.valid_out) pulses++;
      @(negedge clk);
    end
    n_total++; if (pulses !== 0) $display("FAIL abort_no_vout got %0d pulses want 0", pulses); else n_pass++;
    accept_vec(4096, ok);
    wait_vout(cyc);
    n_total++;
    if (!ok || cyc != 18 || exp_q.size() == 0) $display("FAIL abort_next got latency %0d want 18", cyc);
    else begin
      e = exp_q.pop_front();
      got = int'($signed(bus_if.final_output));
      if (got !== e) $display("FAIL abort_next got %0d want %0d", got, e); else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b0;
    bus_if.valid_in = 1'b0;
    bus_if.input_data = '0;
    bus_if.bias = '0;
    for (int i = 0; i < 16; i++) begin
      w_mem[i] = '0;
      x_v[i] = '0;
    end
    bias_v = '0;
    test_reset();
    test_basic();
    test_reset();
    test_values();
    test_random();
    test_back_to_back();
    test_abort();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
